alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Initiator for the 8-bit combinational ALU.
- Latches one operand set and steps the 3-bit opcode from a start code to an end code, wrapping if needed.
- Drives the ALU inputs, waits a fixed settle time, captures sum/c_out, and streams each tagged result out on a valid/ready interface.
- Sits between a test/control master and the ALU; used for self-check sweeps and batch op evaluation.

Parameters:
- WIDTH, 8, operand/result width.
- OPW, 3, opcode width; sweep range 0..2^OPW-1.
- SETTLE, 2, cycles ALU inputs are held before capture (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_a  in  WIDTH  operand a, latched on accepted start.
- in_b  in  WIDTH  operand b, latched on accepted start.
- in_cin  in  1  carry-in, latched on accepted start.
- first_op  in  OPW  first opcode, latched on accepted start.
- last_op  in  OPW  last opcode, latched on accepted start.
- alu_oper  out  OPW  to ALU oper.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_cin  out  1  to ALU c_in.
- alu_sum  in  WIDTH  from ALU sum.
- alu_cout  in  1  from ALU c_out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_oper  out  OPW  opcode tag of result.
- res_sum  out  WIDTH  captured sum.
- res_cout  out  1  captured c_out.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after last result accepted.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, settle counter 0, operand registers 0.
- All outputs are registered; no combinational path from any input to any output.
- IDLE: start=1 latches in_a, in_b, in_cin, first_op, last_op; alu_oper<=first_op; alu_a, alu_b, alu_cin<=latched values; settle counter<=0; go to DRIVE.
- DRIVE: ALU inputs held stable. Counter increments each cycle; when counter==SETTLE-1, go to CAPTURE.
- CAPTURE (one cycle): res_sum<=alu_sum; res_cout<=alu_cout; res_oper<=alu_oper; res_valid<=1; go to EMIT.
- EMIT:
  - Hold res_* stable while res_valid=1 and res_ready=0.
  - On res_valid&res_ready: res_valid<=0.
  - If alu_oper==last_op: go to DONE.
  - Else: alu_oper<=alu_oper+1 (modulo 2^OPW; 7 wraps to 0), counter<=0, go to DRIVE.
- DONE (one cycle): done=1; next IDLE, busy drops the same edge.
- Op count: ((last_op-first_op) mod 2^OPW)+1.
  - first_op==last_op gives exactly 1 op.
  - last_op<first_op wraps, e.g. 6->1 gives 6,7,0,1.
- Per-op latency, start/advance to res_valid: SETTLE+1 cycles. Minimum 8-op sweep with res_ready tied high: 8*(SETTLE+2)+2 cycles from start to done.
- start while busy: ignored, with no effect on latched values.
- Operand inputs may change after start without affecting the sweep.
- res_ready high outside EMIT: ignored.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. Any partially emitted result is discarded; no done pulse.

Decomposition:
- Shared package/header alu_seq_defs: state encoding constants (ST_IDLE, ST_DRIVE, ST_CAPTURE, ST_EMIT, ST_DONE as 3-bit localparams) and default WIDTH/OPW.
- No sub-module required. The settle counter may optionally be split out as alu_settle_cnt (load/terminal-count only).
- The top-level bench instantiates alu_op_sequencer plus the existing ALU.

Test Plan:
- Full sweep, ALU hookup, SETTLE=2, res_ready=1: a=8'h3B, b=8'h66, cin=1, first=0, last=7 -> 8 results tagged 0..7 in order, each matching direct ALU evaluation. For oper=0 (add with carry), sum=8'hA2, cout=0. done pulses once, 34 cycles after start.
- Wrap range: first=6, last=1 -> exactly 4 results tagged 6,7,0,1. busy high throughout; done once.
- Backpressure: res_ready low for 5 cycles on op 3 -> res_valid held and res_oper/sum/cout stable those cycles; alu_oper stays 3; sweep resumes on accept with no loss or duplicate.
- Single op and ignored start: first=last=5 -> one result tagged 5. A second start pulsed mid-sweep with a=8'hFF -> ignored; result still uses a=8'h3B.
- Reset mid-operation: rst_n low during EMIT of op 2 -> all outputs 0 asynchronously, no done. After release, IDLE with busy=0; a new start runs a full clean sweep.
- Settle timing: SETTLE=1 vs SETTLE=4 -> start-to-first-res_valid equals 2 and 5 cycles respectively. alu_* inputs constant from DRIVE entry until capture.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU opcode sequencer: FSM state encoding and
// default datapath widths.
package alu_op_sequencer_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int OPW_DEF   = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Steps an 8-bit combinational ALU through an opcode range on one latched
// operand set, streaming each tagged result out over valid/ready.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int OPW    = OPW_DEF,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [OPW-1:0]   first_op,
    input  logic [OPW-1:0]   last_op,
    output logic [OPW-1:0]   alu_oper,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OPW-1:0]   res_oper,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    seq_state_t     state, state_next;
    logic [CW-1:0]  settle_cnt;
    logic [OPW-1:0] last_op_q;
    logic           settle_done;
    logic           last_op_hit;

    assign settle_done = (settle_cnt == CW'(SETTLE - 1));
    assign last_op_hit = (alu_oper == last_op_q);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next is assigned before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_DRIVE;
            ST_DRIVE:   if (settle_done) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_EMIT;
            ST_EMIT:    if (res_ready) state_next = last_op_hit ? ST_DONE : ST_DRIVE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // The ALU input registers double as the latched operand set, so inputs
    // changing after start cannot disturb an ongoing sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_oper   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            last_op_q  <= '0;
            settle_cnt <= '0;
            res_valid  <= 1'b0;
            res_oper   <= '0;
            res_sum    <= '0;
            res_cout   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_next != ST_IDLE);
            done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        alu_a      <= in_a;
                        alu_b      <= in_b;
                        alu_cin    <= in_cin;
                        alu_oper   <= first_op;
                        last_op_q  <= last_op;
                        settle_cnt <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (!settle_done) settle_cnt <= settle_cnt + 1'b1;
                end
                ST_CAPTURE: begin
                    res_sum   <= alu_sum;
                    res_cout  <= alu_cout;
                    res_oper  <= alu_oper;
                    res_valid <= 1'b1;
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        // Opcode increment wraps naturally at 2^OPW.
                        if (!last_op_hit) begin
                            alu_oper   <= alu_oper + 1'b1;
                            settle_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer driving a behavioural 8-bit ALU; extra
// SETTLE=1 and SETTLE=4 instances cover settle timing.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start_t;
    logic [7:0] in_a, in_b;
    logic       in_cin;
    logic [2:0] first_op, last_op;
    logic       res_ready;

    logic [2:0] alu_oper, res_oper;
    logic [7:0] alu_a, alu_b, alu_sum, res_sum;
    logic       alu_cin, alu_cout, res_valid, res_cout, busy, done;

    logic [2:0] s1_alu_oper, s1_res_oper, s4_alu_oper, s4_res_oper;
    logic [7:0] s1_alu_a, s1_alu_b, s1_alu_sum, s1_res_sum;
    logic [7:0] s4_alu_a, s4_alu_b, s4_alu_sum, s4_res_sum;
    logic       s1_alu_cin, s1_alu_cout, s1_res_valid, s1_res_cout, s1_busy, s1_done;
    logic       s4_alu_cin, s4_alu_cout, s4_res_valid, s4_res_cout, s4_busy, s4_done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int start_cyc;
    logic [2:0] q_oper[$];
    logic [7:0] q_sum[$];
    logic       q_cout[$];

    // Behavioural model of the existing ALU: returns {c_out, sum}.
    function automatic logic [8:0] alu_eval(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
            3'd1:    return {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a[7], a[6:0], cin};
            3'd6:    return {a[0], cin, a[7:1]};
            default: return {1'b0, ~a};
        endcase
    endfunction

    // Hand-computed {c_out, sum} for a=8'h3B, b=8'h66, cin=1.
    function automatic logic [8:0] exp_res(input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, 8'hA2};
            3'd1:    return {1'b0, 8'hD5};
            3'd2:    return {1'b0, 8'h22};
            3'd3:    return {1'b0, 8'h7F};
            3'd4:    return {1'b0, 8'h5D};
            3'd5:    return {1'b0, 8'h77};
            3'd6:    return {1'b1, 8'h9D};
            default: return {1'b0, 8'hC4};
        endcase
    endfunction

    assign {alu_cout, alu_sum}       = alu_eval(alu_oper, alu_a, alu_b, alu_cin);
    assign {s1_alu_cout, s1_alu_sum} = alu_eval(s1_alu_oper, s1_alu_a, s1_alu_b, s1_alu_cin);
    assign {s4_alu_cout, s4_alu_sum} = alu_eval(s4_alu_oper, s4_alu_a, s4_alu_b, s4_alu_cin);

    alu_op_sequencer #(.WIDTH(8), .OPW(3), .SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .first_op(first_op), .last_op(last_op),
        .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_sum(alu_sum), .alu_cout(alu_cout), .res_valid(res_valid),
        .res_ready(res_ready), .res_oper(res_oper), .res_sum(res_sum),
        .res_cout(res_cout), .busy(busy), .done(done)
    );

    alu_op_sequencer #(.WIDTH(8), .OPW(3), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_t), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .first_op(first_op), .last_op(last_op),
        .alu_oper(s1_alu_oper), .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_cin(s1_alu_cin),
        .alu_sum(s1_alu_sum), .alu_cout(s1_alu_cout), .res_valid(s1_res_valid),
        .res_ready(1'b1), .res_oper(s1_res_oper), .res_sum(s1_res_sum),
        .res_cout(s1_res_cout), .busy(s1_busy), .done(s1_done)
    );

    alu_op_sequencer #(.WIDTH(8), .OPW(3), .SETTLE(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start_t), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .first_op(first_op), .last_op(last_op),
        .alu_oper(s4_alu_oper), .alu_a(s4_alu_a), .alu_b(s4_alu_b), .alu_cin(s4_alu_cin),
        .alu_sum(s4_alu_sum), .alu_cout(s4_alu_cout), .res_valid(s4_res_valid),
        .res_ready(1'b1), .res_oper(s4_res_oper), .res_sum(s4_res_sum),
        .res_cout(s4_res_cout), .busy(s4_busy), .done(s4_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes and done pulses are observed mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                q_oper.push_back(res_oper);
                q_sum.push_back(res_sum);
                q_cout.push_back(res_cout);
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; scrambles operands after.
    task automatic start_sweep(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               input logic [2:0] f, input logic [2:0] l);
        in_a = a; in_b = b; in_cin = cin; first_op = f; last_op = l;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        in_a = ~a; in_b = ~b; in_cin = ~cin; first_op = ~f; last_op = ~l;
    endtask

    task automatic wait_done(output int gaps, output int done_cyc);
        gaps = 0;
        done_cyc = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (!busy) gaps++;
            @(posedge clk); #1;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        done_cyc = cyc;
    endtask

    task automatic wait_oper(input logic [2:0] op);
        for (int i = 0; i < 100 && alu_oper != op; i++) begin
            @(posedge clk); #1;
        end
        chk("reach_oper", {29'd0, alu_oper}, {29'd0, op});
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100 && !res_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("reach_valid", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic clear_q();
        q_oper.delete(); q_sum.delete(); q_cout.delete();
    endtask

    task automatic check_results(input string tag, input logic [2:0] f, input int n);
        logic [2:0] op;
        logic [8:0] e;
        chk({tag, "_count"}, q_oper.size(), n);
        op = f;
        for (int i = 0; i < n && i < q_oper.size(); i++) begin
            e = exp_res(op);
            chk($sformatf("%s_tag%0d", tag, i), {29'd0, q_oper[i]}, {29'd0, op});
            chk($sformatf("%s_sum%0d", tag, i), {24'd0, q_sum[i]}, {24'd0, e[7:0]});
            chk($sformatf("%s_cout%0d", tag, i), {31'd0, q_cout[i]}, {31'd0, e[8]});
            op = op + 3'd1;
        end
    endtask

    initial begin
        int gaps, done_cyc, d0, lat1, lat4;

        rst_n = 1'b0; start = 1'b0; start_t = 1'b0; res_ready = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0; first_op = '0; last_op = '0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_outs", {alu_oper, alu_a, alu_b, alu_cin, res_oper, res_sum[3:0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full 0..7 sweep with res_ready held high.
        clear_q();
        d0 = done_cnt;
        start_sweep(8'h3B, 8'h66, 1'b1, 3'd0, 3'd7);
        wait_done(gaps, done_cyc);
        chk("full_done_latency", done_cyc - start_cyc, 34);
        chk("full_busy_gaps", gaps, 0);
        repeat (2) @(posedge clk); #1;
        chk("full_done_once", done_cnt - d0, 1);
        chk("full_busy_after", {31'd0, busy}, 32'd0);
        check_results("full", 3'd0, 8);

        // Wrapped range 6 -> 1.
        clear_q();
        d0 = done_cnt;
        start_sweep(8'h3B, 8'h66, 1'b1, 3'd6, 3'd1);
        wait_done(gaps, done_cyc);
        chk("wrap_busy_gaps", gaps, 0);
        repeat (2) @(posedge clk); #1;
        chk("wrap_done_once", done_cnt - d0, 1);
        check_results("wrap", 3'd6, 4);

        // Backpressure on op 3 for five cycles.
        clear_q();
        start_sweep(8'h3B, 8'h66, 1'b1, 3'd2, 3'd4);
        wait_oper(3'd3);
        res_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid%0d", i), {31'd0, res_valid}, 32'd1);
            chk($sformatf("bp_oper%0d", i), {29'd0, res_oper}, 32'd3);
            chk($sformatf("bp_sum%0d", i), {23'd0, res_cout, res_sum}, 32'h07F);
            chk($sformatf("bp_alu_oper%0d", i), {29'd0, alu_oper}, 32'd3);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        wait_done(gaps, done_cyc);
        @(posedge clk); #1;
        check_results("bp", 3'd2, 3);

        // Single op; a start pulsed mid-sweep must be ignored.
        clear_q();
        d0 = done_cnt;
        start_sweep(8'h3B, 8'h66, 1'b1, 3'd5, 3'd5);
        in_a = 8'hFF; first_op = 3'd0; last_op = 3'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_alu_a", {24'd0, alu_a}, 32'h3B);
        chk("ign_alu_oper", {29'd0, alu_oper}, 32'd5);
        wait_done(gaps, done_cyc);
        repeat (2) @(posedge clk); #1;
        chk("single_done_once", done_cnt - d0, 1);
        check_results("single", 3'd5, 1);

        // Asynchronous reset during EMIT of op 2.
        start_sweep(8'h3B, 8'h66, 1'b1, 3'd0, 3'd7);
        wait_oper(3'd2);
        res_ready = 1'b0;
        wait_valid();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_outs", {alu_oper, alu_a, alu_b, alu_cin, res_oper, res_sum[3:0]}, 32'd0);
        chk("mid_rst_res_sum", {24'd0, res_sum}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_no_done", done_cnt - d0, 0);
        clear_q();
        start_sweep(8'h3B, 8'h66, 1'b1, 3'd0, 3'd7);
        wait_done(gaps, done_cyc);
        chk("post_rst_latency", done_cyc - start_cyc, 34);
        @(posedge clk); #1;
        check_results("post_rst", 3'd0, 8);

        // Settle timing on the SETTLE=1 and SETTLE=4 instances.
        lat1 = 0; lat4 = 0;
        in_a = 8'h3B; in_b = 8'h66; in_cin = 1'b1; first_op = 3'd0; last_op = 3'd0;
        start_t = 1'b1;
        @(posedge clk); #1;
        start_t = 1'b0;
        in_a = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (s1_res_valid && lat1 == 0) lat1 = k;
            if (s4_res_valid && lat4 == 0) lat4 = k;
            if (k <= 4) chk($sformatf("s4_alu_a_k%0d", k), {24'd0, s4_alu_a}, 32'h3B);
        end
        chk("s1_latency", lat1, 2);
        chk("s4_latency", lat4, 5);
        chk("s4_res", {23'd0, s4_res_cout, s4_res_sum}, 32'h0A2);
        chk("s1_res", {23'd0, s1_res_cout, s1_res_sum}, 32'h0A2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
